// File: rtl/risc_16bit.sv
`default_nettype none
// ============================================================================
//  Module   : risc_16bit
//  Purpose  : Single-issue 16-bit RISC core, one instruction per clock, with a
//             unified instruction/data RAM that a host preloads while the core
//             is frozen. Results leave through an output register and a
//             one-cycle strobe; HLT raises a sticky done flag.
//  Ports    : CLK       - clock, all state changes on the rising edge
//             rst_n     - synchronous reset, ACTIVE-HIGH despite the name
//             E         - run enable (1 = execute, 0 = frozen / load mode)
//             Ram_addr  - host write address (upper bits beyond ADDR_W ignored)
//             Ram_data  - host write data
//             WR_RAM_E  - host write strobe, honoured only while E = 0
//             out_data  - value of the most recent OUT instruction
//             out_flag  - strobe, high the cycle after an OUT executes
//             done      - sticky halt indicator
//  Revision : 1.0 - initial release
// ============================================================================
module risc_16bit #(
    parameter int ADDR_W = 8
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        E,
    input  logic [15:0] Ram_addr,
    input  logic [15:0] Ram_data,
    input  logic        WR_RAM_E,
    output logic [15:0] out_data,
    output logic        out_flag,
    output logic        done
);

    localparam int              c_DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_PC_ONE = ADDR_W'(1);

    localparam logic [3:0] c_OP_NOP  = 4'h0;
    localparam logic [3:0] c_OP_ADD  = 4'h1;
    localparam logic [3:0] c_OP_SUB  = 4'h2;
    localparam logic [3:0] c_OP_AND  = 4'h3;
    localparam logic [3:0] c_OP_OR   = 4'h4;
    localparam logic [3:0] c_OP_XOR  = 4'h5;
    localparam logic [3:0] c_OP_SHL  = 4'h6;
    localparam logic [3:0] c_OP_SHR  = 4'h7;
    localparam logic [3:0] c_OP_LDI  = 4'h8;
    localparam logic [3:0] c_OP_LUI  = 4'h9;
    localparam logic [3:0] c_OP_LD   = 4'hA;
    localparam logic [3:0] c_OP_ST   = 4'hB;
    localparam logic [3:0] c_OP_BEQZ = 4'hC;
    localparam logic [3:0] c_OP_JMP  = 4'hD;
    localparam logic [3:0] c_OP_OUT  = 4'hE;
    localparam logic [3:0] c_OP_HLT  = 4'hF;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [15:0]       r_mem [0:c_DEPTH-1];
    logic [15:0]       r_regs [0:7];
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_out_data;
    logic              r_out_flag;
    logic              r_done;

    // ------------------------------------------------------------------------
    // Fetch / decode (RAM read is combinational)
    // ------------------------------------------------------------------------
    logic [15:0]       w_instr;
    logic [3:0]        w_op;
    logic [2:0]        w_rd;
    logic [2:0]        w_rs1;
    logic [2:0]        w_rs2;
    logic [15:0]       w_rd_val;
    logic [15:0]       w_rs1_val;
    logic [15:0]       w_rs2_val;
    logic [15:0]       w_imm9_sext;
    logic [ADDR_W-1:0] w_imm6_addr;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_jmp_tgt;
    logic [ADDR_W-1:0] w_ea;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [15:0]       w_ld_data;
    logic              w_exec;

    assign w_instr     = r_mem[r_pc];
    assign w_op        = w_instr[15:12];
    assign w_rd        = w_instr[11:9];
    assign w_rs1       = w_instr[8:6];
    assign w_rs2       = w_instr[5:3];

    // R0 is hard-wired to zero on every read port.
    assign w_rd_val    = (w_rd  == 3'd0) ? 16'd0 : r_regs[w_rd];
    assign w_rs1_val   = (w_rs1 == 3'd0) ? 16'd0 : r_regs[w_rs1];
    assign w_rs2_val   = (w_rs2 == 3'd0) ? 16'd0 : r_regs[w_rs2];

    assign w_imm9_sext = {{7{w_instr[8]}}, w_instr[8:0]};
    // Address-domain immediates: sign-extended (or zero-extended for JMP)
    // straight to the RAM address width, so the arithmetic wraps naturally.
    assign w_imm6_addr = ADDR_W'($signed(w_instr[5:0]));
    assign w_br_off    = ADDR_W'($signed(w_instr[8:0]));
    assign w_jmp_tgt   = ADDR_W'(w_instr[11:0]);

    assign w_ea        = w_rs1_val[ADDR_W-1:0] + w_imm6_addr;
    assign w_ld_data   = r_mem[w_ea];
    assign w_pc_inc    = r_pc + c_PC_ONE;

    // Core advances only while enabled and not halted.
    assign w_exec      = E && !r_done;

    // ------------------------------------------------------------------------
    // Execute: next PC, register write-back, memory write, OUT and HLT
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_rf_we;
    logic [15:0]       w_rf_wdata;
    logic              w_mem_we;
    logic              w_out_fire;
    logic              w_halt;

    always_comb begin
        w_pc_next  = w_pc_inc;
        w_rf_we    = 1'b0;
        w_rf_wdata = 16'd0;
        w_mem_we   = 1'b0;
        w_out_fire = 1'b0;
        w_halt     = 1'b0;

        case (w_op)
            c_OP_NOP: ;
            c_OP_ADD: begin w_rf_we = 1'b1; w_rf_wdata = w_rs1_val + w_rs2_val; end
            c_OP_SUB: begin w_rf_we = 1'b1; w_rf_wdata = w_rs1_val - w_rs2_val; end
            c_OP_AND: begin w_rf_we = 1'b1; w_rf_wdata = w_rs1_val & w_rs2_val; end
            c_OP_OR:  begin w_rf_we = 1'b1; w_rf_wdata = w_rs1_val | w_rs2_val; end
            c_OP_XOR: begin w_rf_we = 1'b1; w_rf_wdata = w_rs1_val ^ w_rs2_val; end
            c_OP_SHL: begin w_rf_we = 1'b1; w_rf_wdata = w_rs1_val << w_rs2_val[3:0]; end
            c_OP_SHR: begin w_rf_we = 1'b1; w_rf_wdata = w_rs1_val >> w_rs2_val[3:0]; end
            c_OP_LDI: begin w_rf_we = 1'b1; w_rf_wdata = w_imm9_sext; end
            // LUI keeps the destination's own low byte.
            c_OP_LUI: begin w_rf_we = 1'b1; w_rf_wdata = {w_instr[7:0], w_rd_val[7:0]}; end
            c_OP_LD:  begin w_rf_we = 1'b1; w_rf_wdata = w_ld_data; end
            c_OP_ST:  w_mem_we = 1'b1;
            c_OP_BEQZ: begin
                if (w_rd_val == 16'd0) begin
                    w_pc_next = w_pc_inc + w_br_off;
                end
            end
            c_OP_JMP: w_pc_next = w_jmp_tgt;
            c_OP_OUT: begin
                // A strobe still high from the previous OUT would merge two
                // outputs into one pulse; hold the PC for one cycle so the
                // flag drops before this OUT retires.
                if (r_out_flag) begin
                    w_pc_next = r_pc;
                end else begin
                    w_out_fire = 1'b1;
                end
            end
            c_OP_HLT: begin
                w_pc_next = r_pc;
                w_halt    = 1'b1;
            end
            default: ;
        endcase

        // Writes to R0 are discarded.
        if (w_rd == 3'd0) begin
            w_rf_we = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Architectural state. Note: rst_n is active-high.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (rst_n) begin
            r_pc       <= '0;
            r_out_data <= 16'd0;
            r_out_flag <= 1'b0;
            r_done     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 16'd0;
            end
        end else begin
            // The strobe lasts exactly one cycle; frozen or halted cycles
            // also force it low.
            r_out_flag <= 1'b0;
            if (w_exec) begin
                r_pc <= w_pc_next;
                if (w_rf_we) begin
                    r_regs[w_rd] <= w_rf_wdata;
                end
                if (w_out_fire) begin
                    r_out_data <= w_rd_val;
                    r_out_flag <= 1'b1;
                end
                if (w_halt) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    // RAM is never cleared by reset. Host writes and ST are mutually
    // exclusive because one needs E=0 and the other E=1.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            if (!E && WR_RAM_E) begin
                r_mem[Ram_addr[ADDR_W-1:0]] <= Ram_data;
            end else if (w_exec && w_mem_we) begin
                r_mem[w_ea] <= w_rd_val;
            end
        end
    end

    // Host address bits above the RAM size are ignored.
    generate
        if (ADDR_W < 16) begin : g_addr_trunc
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^Ram_addr[15:ADDR_W];
        end
    endgenerate

    assign out_data = r_out_data;
    assign out_flag = r_out_flag;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_risc_16bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_risc_16bit
//  Purpose  : Self-checking bench for risc_16bit. Directed programs plus
//             randomised ALU programs whose expected OUT stream comes from an
//             instruction-level interpreter of the ISA kept in the bench.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_risc_16bit;

    localparam int AW  = 8;
    localparam int MSZ = 1 << AW;

    logic        CLK;
    logic        rst_n;
    logic        E;
    logic [15:0] Ram_addr;
    logic [15:0] Ram_data;
    logic        WR_RAM_E;
    logic [15:0] out_data;
    logic        out_flag;
    logic        done;

    risc_16bit #(.ADDR_W(AW)) dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .E        (E),
        .Ram_addr (Ram_addr),
        .Ram_data (Ram_data),
        .WR_RAM_E (WR_RAM_E),
        .out_data (out_data),
        .out_flag (out_flag),
        .done     (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          checks   = 0;
    int          failures = 0;

    logic [15:0] sh_mem [MSZ];   // what the DUT RAM is expected to hold
    logic [15:0] prog   [$];
    logic [15:0] exp_q  [$];
    logic [15:0] got_q  [$];
    int          flag_cyc [$];
    int          cyc;
    int          done_cyc;
    int          consec_err;
    bit          prev_flag;

    // ---------------------------------------------------------------- encoders
    function automatic logic [15:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
        return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
    endfunction

    function automatic logic [15:0] enc_i9(input int op, input int rd, input int imm9);
        return {4'(op), 3'(rd), 9'(imm9)};
    endfunction

    // -------------------------------------------------------- reference model
    // Interprets the program in sh_mem from PC 0 until HLT and records every
    // OUT value in exp_q; the stall rule only affects timing, not the stream.
    task automatic model_run();
        logic [15:0] m [MSZ];
        logic [15:0] r [8];
        logic [15:0] ins, a, b, d, res;
        int          pc, op, rd, rs1, rs2, s9, s6, nxt;
        bit          wr;
        for (int i = 0; i < MSZ; i++) m[i] = sh_mem[i];
        for (int i = 0; i < 8; i++) r[i] = 16'd0;
        pc = 0;
        exp_q.delete();
        for (int step = 0; step < 4000; step++) begin
            ins = m[pc];
            op  = int'(ins[15:12]);
            rd  = int'(ins[11:9]);
            rs1 = int'(ins[8:6]);
            rs2 = int'(ins[5:3]);
            a = r[rs1]; b = r[rs2]; d = r[rd];
            s9 = int'(ins[8:0]); if (s9 >= 256) s9 -= 512;
            s6 = int'(ins[5:0]); if (s6 >= 32)  s6 -= 64;
            nxt = (pc + 1) % MSZ;
            wr  = 1'b0;
            res = 16'd0;
            if (op == 15) break;
            case (op)
                1:  begin res = a + b; wr = 1'b1; end
                2:  begin res = a - b; wr = 1'b1; end
                3:  begin res = a & b; wr = 1'b1; end
                4:  begin res = a | b; wr = 1'b1; end
                5:  begin res = a ^ b; wr = 1'b1; end
                6:  begin res = a << (int'(b) % 16); wr = 1'b1; end
                7:  begin res = a >> (int'(b) % 16); wr = 1'b1; end
                8:  begin res = 16'(s9); wr = 1'b1; end
                9:  begin res = 16'(int'(d) % 256 + int'(ins[7:0]) * 256); wr = 1'b1; end
                10: begin res = m[((int'(a) + s6) % MSZ + MSZ) % MSZ]; wr = 1'b1; end
                11: m[((int'(a) + s6) % MSZ + MSZ) % MSZ] = d;
                12: if (d == 16'd0) nxt = ((pc + 1 + s9) % MSZ + MSZ) % MSZ;
                13: nxt = int'(ins[11:0]) % MSZ;
                14: exp_q.push_back(d);
                default: ;
            endcase
            if (wr && rd != 0) r[rd] = res;
            pc = nxt;
        end
        for (int i = 0; i < MSZ; i++) sh_mem[i] = m[i];
    endtask

    // ------------------------------------------------------------- bus tasks
    // All tasks start and end just after a falling edge.
    task automatic do_reset();
        E = 1'b0;
        rst_n = 1'b1;
        @(posedge CLK); @(negedge CLK);
        rst_n = 1'b0;
        got_q.delete();
        flag_cyc.delete();
        cyc = 0; done_cyc = -1; consec_err = 0; prev_flag = 1'b0;
    endtask

    task automatic host_wr(input logic [15:0] addr, input logic [15:0] data);
        Ram_addr = addr; Ram_data = data; WR_RAM_E = 1'b1;
        if (!E) sh_mem[int'(addr) % MSZ] = data;
        @(posedge CLK); @(negedge CLK);
        WR_RAM_E = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog.size(); i++) host_wr(16'(i), prog[i]);
    endtask

    task automatic run_cycles(input int n);
        E = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); @(negedge CLK);
            cyc++;
            if (out_flag === 1'b1) begin
                if (prev_flag) consec_err++;
                got_q.push_back(out_data);
                flag_cyc.push_back(cyc);
            end
            prev_flag = (out_flag === 1'b1);
            if (done === 1'b1) begin
                if (done_cyc < 0) done_cyc = cyc;
                break;
            end
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        do_reset();
        checks++; if (out_data !== 16'd0) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        checks++; if (out_flag !== 1'b0)  begin failures++; $display("FAIL reset_out_flag got=%b exp=0", out_flag); end
        checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    endtask

    task automatic test_basic_program();
        do_reset();
        prog = '{16'h8205, 16'h8403, 16'h1650, 16'hE600, 16'hF000};
        load_prog();
        run_cycles(50);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_timeout done=%b exp=1", done); end
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL basic_pulses got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++; if (got_q[0] !== 16'h0008) begin failures++; $display("FAIL basic_value got=%h exp=0008", got_q[0]); end
            checks++; if (done_cyc != flag_cyc[0] + 1) begin failures++; $display("FAIL basic_done_lat got=%0d exp=%0d", done_cyc, flag_cyc[0] + 1); end
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); @(negedge CLK);
            checks++;
            if (done !== 1'b1 || out_flag !== 1'b0) begin
                failures++; $display("FAIL basic_sticky done=%b flag=%b exp done=1 flag=0", done, out_flag);
            end
        end
        E = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        prog = '{16'h8205, 16'h8403, 16'hE200, 16'hE400, 16'hF000};
        load_prog();
        run_cycles(50);
        E = 1'b0;
        checks++; if (got_q.size() != 2 || consec_err != 0) begin
            failures++; $display("FAIL b2b_pulses got=%0d consec=%0d exp=2 consec=0", got_q.size(), consec_err);
        end
        if (got_q.size() == 2) begin
            checks++; if (got_q[0] !== 16'h0005 || got_q[1] !== 16'h0003) begin
                failures++; $display("FAIL b2b_values got=%h,%h exp=0005,0003", got_q[0], got_q[1]);
            end
            checks++; if (flag_cyc[1] - flag_cyc[0] != 2) begin
                failures++; $display("FAIL b2b_gap got=%0d exp=2", flag_cyc[1] - flag_cyc[0]);
            end
        end
    endtask

    task automatic test_shift_lui();
        do_reset();
        prog = '{16'h83FF, 16'h8604, 16'h7458, 16'hE400, 16'h8234, 16'h9212, 16'hE200, 16'hF000};
        load_prog();
        run_cycles(50);
        E = 1'b0;
        checks++; if (got_q.size() != 2) begin failures++; $display("FAIL shlui_count got=%0d exp=2", got_q.size()); end
        if (got_q.size() == 2) begin
            checks++; if (got_q[0] !== 16'h0FFF) begin failures++; $display("FAIL shr_value got=%h exp=0fff", got_q[0]); end
            checks++; if (got_q[1] !== 16'h1234) begin failures++; $display("FAIL lui_value got=%h exp=1234", got_q[1]); end
        end
    endtask

    task automatic test_ld_st();
        logic [15:0] v;
        v = 16'($urandom);
        do_reset();
        prog = '{enc_i9(8, 1, int'(v[7:0])), {4'h9, 3'd1, 1'b0, v[15:8]},
                 enc_i9(8, 5, 'h40), 16'hB340, 16'hA940, 16'hE800, 16'hF000};
        load_prog();
        run_cycles(50);
        checks++; if (got_q.size() != 1 || got_q[0] !== v) begin
            failures++; $display("FAIL ldst_value got=%h n=%0d exp=%h", (got_q.size() > 0) ? got_q[0] : 16'h0, got_q.size(), v);
        end
        // E is still high here: this write must be ignored.
        host_wr(16'h0040, ~v);
        do_reset();
        prog = '{16'h8C41, 16'hA9BF, 16'hE800, 16'hF000};
        load_prog();
        run_cycles(50);
        E = 1'b0;
        checks++; if (got_q.size() != 1 || got_q[0] !== v) begin
            failures++; $display("FAIL ldst_write_blocked got=%h n=%0d exp=%h", (got_q.size() > 0) ? got_q[0] : 16'h0, got_q.size(), v);
        end
    endtask

    task automatic test_countdown();
        do_reset();
        prog = '{16'h8203, 16'hE200, 16'h8401, 16'h2250, 16'hC201, 16'hD001, 16'hF000};
        load_prog();
        run_cycles(100);
        E = 1'b0;
        checks++; if (done !== 1'b1 || got_q.size() != 3) begin
            failures++; $display("FAIL loop_count got=%0d done=%b exp=3 done=1", got_q.size(), done);
        end
        if (got_q.size() == 3) begin
            checks++; if (got_q[0] !== 16'd3 || got_q[1] !== 16'd2 || got_q[2] !== 16'd1) begin
                failures++; $display("FAIL loop_values got=%h,%h,%h exp=0003,0002,0001", got_q[0], got_q[1], got_q[2]);
            end
        end
    endtask

    task automatic test_pause_and_reset();
        do_reset();
        prog = '{16'h8205, 16'hE200, 16'h8401, 16'h2250, 16'hC201, 16'hD001, 16'hF000};
        load_prog();
        model_run();
        run_cycles(2);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL pause_first_out got=%0d exp=1", got_q.size()); end
        E = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); @(negedge CLK);
            checks++;
            if (out_flag !== 1'b0 || done !== 1'b0 || out_data !== exp_q[0]) begin
                failures++; $display("FAIL pause_hold flag=%b done=%b data=%h exp flag=0 done=0 data=%h", out_flag, done, out_data, exp_q[0]);
            end
        end
        prev_flag = 1'b0;
        run_cycles(200);
        E = 1'b0;
        checks++; if (got_q.size() != exp_q.size() || consec_err != 0 || done !== 1'b1) begin
            failures++; $display("FAIL pause_resume_count got=%0d exp=%0d consec=%0d done=%b", got_q.size(), exp_q.size(), consec_err, done);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL pause_resume_value[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        // Reset in the middle of a second run, then rerun from scratch.
        do_reset();
        run_cycles(4);
        do_reset();
        checks++; if (out_data !== 16'd0 || out_flag !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL midrun_reset data=%h flag=%b done=%b exp 0000/0/0", out_data, out_flag, done);
        end
        run_cycles(200);
        E = 1'b0;
        checks++; if (got_q.size() != exp_q.size() || done !== 1'b1) begin
            failures++; $display("FAIL rerun_count got=%0d exp=%0d done=%b", got_q.size(), exp_q.size(), done);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rerun_value[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random_alu();
        int sel;
        for (int it = 0; it < 16; it++) begin
            do_reset();
            prog.delete();
            for (int r = 1; r < 8; r++) prog.push_back(enc_i9(8, r, int'($urandom_range(0, 511))));
            for (int k = 0; k < 14; k++) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 7)
                    prog.push_back(enc_r(sel + 1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
                else if (sel == 7)
                    prog.push_back(enc_i9(9, int'($urandom_range(0, 7)), int'($urandom_range(0, 511))));
                else
                    prog.push_back(enc_r(14, int'($urandom_range(0, 7)), 0, 0));
            end
            prog.push_back(enc_r(14, int'($urandom_range(1, 7)), 0, 0));
            prog.push_back(16'hF000);
            load_prog();
            model_run();
            run_cycles(200);
            E = 1'b0;
            checks++; if (got_q.size() != exp_q.size() || consec_err != 0 || done !== 1'b1) begin
                failures++; $display("FAIL rand%0d_count got=%0d exp=%0d consec=%0d done=%b", it, got_q.size(), exp_q.size(), consec_err, done);
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_value[%0d] got=%h exp=%h", it, i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; E = 1'b0; Ram_addr = 16'd0; Ram_data = 16'd0; WR_RAM_E = 1'b0;
        for (int i = 0; i < MSZ; i++) sh_mem[i] = 16'd0;
        cyc = 0; done_cyc = -1; consec_err = 0; prev_flag = 1'b0;
        @(negedge CLK);
        test_reset();
        test_basic_program();
        test_back_to_back();
        test_shift_lui();
        test_ld_st();
        test_countdown();
        test_pause_and_reset();
        test_random_alu();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/risc_16bit.md
Name: risc_16bit

Overview:
Single-issue 16-bit RISC CPU with a unified internal instruction/data RAM, eight 16-bit registers and one instruction per cycle.
While the run enable E is low, a host preloads the RAM through a write port; raising E executes from address 0.
Results leave via an output register with a one-cycle strobe; HLT raises a sticky done.

Parameters:
ADDR_W, 8, RAM address width (2^ADDR_W words of 16 bits); upper Ram_addr/PC bits ignored.

Ports:
CLK  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-high (asserted when 1)
E  in  1  run enable; 1 = execute, 0 = frozen/load mode
Ram_addr  in  16  host write address
Ram_data  in  16  host write data
WR_RAM_E  in  1  host write strobe
out_data  out  16  value of last OUT instruction
out_flag  out  1  one-cycle strobe, high the cycle after OUT executes
done  out  1  sticky halt indicator

Behaviour:
- Reset (rst_n=1 at edge): PC=0, R0..R7=0, out_data=0, out_flag=0, done=0. RAM contents not cleared.
- Host write: at edge, if WR_RAM_E=1 and E=0, MEM[Ram_addr[ADDR_W-1:0]] <= Ram_data. Ignored when E=1.
- RAM read is combinational (instruction fetch at PC, load data at effective address); writes synchronous.
- Execute one instruction per edge when E=1, done=0, rst_n=0. E=0: PC/regs/outputs hold; out_flag forced 0.
- R0 reads 0; writes to R0 discarded.
- Format: op=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm6=[5:0], imm9=[8:0], imm12=[11:0]; immediates sign-extended except LUI/JMP.
- PC <= PC+1 (mod 2^ADDR_W) unless stated. All arithmetic mod 2^16, no flags.
- 0 NOP.
- 1 ADD rd=rs1+rs2; 2 SUB rd=rs1-rs2; 3 AND; 4 OR; 5 XOR.
- 6 SHL rd=rs1<<rs2[3:0]; 7 SHR rd=rs1>>rs2[3:0] (logical).
- 8 LDI rd=sext(imm9).
- 9 LUI rd={instr[7:0], rd[7:0]}.
- A LD rd=MEM[rs1+sext(imm6)]; B ST MEM[rs1+sext(imm6)]=rd (address truncated to ADDR_W).
- C BEQZ: if rd==0, PC=PC+1+sext(imm9); rd=R0 is an unconditional branch.
- D JMP PC=imm12[ADDR_W-1:0].
- E OUT: out_data<=rd, out_flag<=1 same edge. If out_flag is already 1, OUT stalls one cycle (PC holds, flag drops) so every OUT produces a distinct rising edge. out_data holds until next OUT.
- F HLT: done<=1, PC holds; no further execution until reset.
- out_flag is 0 in every cycle not immediately following an executed OUT.
- Reset has priority over E, host writes, and execution; reset mid-run restarts at PC=0 with RAM retained.

Test Plan:
- Reset then load 0:8205, 1:8403, 2:1650, 3:E600, 4:F000 with E=0, raise E -> out_flag pulses once, out_data=0x0008, done=1 one cycle later; done stays 1.
- Back-to-back OUT R1/OUT R2 (R1=5, R2=3) -> two separate out_flag pulses with a low cycle between; out_data 0x0005 then 0x0003.
- LDI R1,-1 (0x83FF); SHR R2,R1,R3 with R3=4; OUT R2 -> 0x0FFF; LUI R1,0x12 after LDI R1,0x34 -> 0x1234.
- ST R1 to address 0x40, LD R4 from it, OUT R4 -> value matches; host write attempt while E=1 -> RAM unchanged.
- Countdown loop: LDI R1,3; loop OUT R1, SUB R1 by 1, BEQZ exit, JMP loop -> outputs 3,2,1 then done=1.
- Drop E mid-program for 10 cycles -> no state change, out_flag=0; raise E -> resumes; assert rst_n mid-run -> outputs cleared, rerun gives identical results.
